// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Matrix keypad scanner with per-key debounce, n-key rollover and an event
// FIFO. Columns are driven active-low, one at a time. Each column is held for
// COL_CYCLES clocks. Rows are sampled once per column through a 2-flop
// synchroniser, SETTLE_CYCLES into the column slot. Every key has its own
// debounce counter. A key's debounced state flips after DEBOUNCE_SCANS
// consecutive samples that disagree with it. Each flip is queued as a
// press/release event in a first-word-fall-through FIFO.
//
// Ports
//   clk_100MHz    system clock
//   rst           asynchronous, active-high reset
//   row           row sense lines, active low (externally pulled up)
//   col           column drive, exactly one bit low
//   ev_valid      FIFO non-empty
//   ev_ready      consumer accepts the head event
//   ev_code       head event key code = row_index*COLS + col_index
//   ev_release    head event type: 0 = press, 1 = release
//   ev_count      number of queued events
//   overflow      sticky flag: an event was dropped because the FIFO was full
//   clr_overflow  synchronous clear of overflow (a same-cycle drop wins)
//   key_down      debounced key map, bit k = key code k held
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int COL_CYCLES     = 100_000,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 8,
  localparam int CODE_W        = $clog2(ROWS * COLS),
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk_100MHz,
  input  logic                   rst,
  input  logic [ROWS-1:0]        row,
  output logic [COLS-1:0]        col,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [CODE_W-1:0]      ev_code,
  output logic                   ev_release,
  output logic [CNT_W-1:0]       ev_count,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [ROWS*COLS-1:0]   key_down
);

  localparam int NKEYS = ROWS * COLS;
  localparam int CYC_W = $clog2(COL_CYCLES);
  localparam int COL_W = $clog2(COLS);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Key code for row r of column c.
  function automatic logic [CODE_W-1:0] key_of(input int r, input logic [COL_W-1:0] c);
    return CODE_W'(r * COLS + int'(c));
  endfunction

  // ---------------------------------------------------------------------------
  // Column scan: dwell counter and registered one-cold column drive
  // ---------------------------------------------------------------------------
  logic [CYC_W-1:0] scan_cnt;
  logic [COL_W-1:0] col_idx;
  logic             col_end;

  assign col_end = (scan_cnt == CYC_W'(COL_CYCLES - 1));

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples the values from before the edge regardless of block order.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      col_idx  <= '0;
      col      <= ~COLS'(1);
    end else if (col_end) begin
      scan_cnt <= '0;
      // Rotating the one-cold pattern keeps col equal to ~(1 << col_idx),
      // including the wrap from the last column back to column 0.
      col      <= {col[COLS-2:0], col[COLS-1]};
      if (col_idx == COL_W'(COLS - 1)) col_idx <= '0;
      else                             col_idx <= col_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Row synchroniser and per-column sample
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0]  row_s1, row_s2, raw;
  logic [COL_W-1:0] samp_col;
  logic             samp_q;    // high the cycle after raw was captured

  // Idle rows are pulled high, so the synchroniser and raw reset to all-ones
  // ("nothing pressed") rather than to zero.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      row_s1   <= '1;
      row_s2   <= '1;
      raw      <= '1;
      samp_col <= '0;
      samp_q   <= 1'b0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      samp_q <= (scan_cnt == CYC_W'(SETTLE_CYCLES - 1));
      if (scan_cnt == CYC_W'(SETTLE_CYCLES - 1)) begin
        raw      <= row_s2;
        samp_col <= col_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce for the column just sampled
  // ---------------------------------------------------------------------------
  logic [NKEYS-1:0][DB_W-1:0] db_cnt, db_cnt_nxt;
  logic [NKEYS-1:0]           key_down_nxt;
  logic [ROWS-1:0]            flag_set;

  // NOTE: every signal driven here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    db_cnt_nxt   = db_cnt;
    key_down_nxt = key_down;
    flag_set     = '0;
    if (samp_q) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!raw[r] == key_down[key_of(r, samp_col)]) begin
          db_cnt_nxt[key_of(r, samp_col)] = '0;
        end else if (db_cnt[key_of(r, samp_col)] == DB_W'(DEBOUNCE_SCANS - 1)) begin
          key_down_nxt[key_of(r, samp_col)] = !raw[r];
          db_cnt_nxt[key_of(r, samp_col)]   = '0;
          flag_set[r]                       = 1'b1;
        end else begin
          db_cnt_nxt[key_of(r, samp_col)] = db_cnt[key_of(r, samp_col)] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      key_down <= '0;
    end else begin
      db_cnt   <= db_cnt_nxt;
      key_down <= key_down_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Event serialiser: one flagged row per cycle, lowest row index first.
  // COL_CYCLES leaves room for all ROWS pushes before samp_col moves on.
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0]   flags;
  logic [ROW_W-1:0]  push_row;
  logic              push_req;
  logic [CODE_W-1:0] push_code;

  always_comb begin
    push_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (flags[r]) push_row = ROW_W'(r);
    end
  end

  assign push_req  = |flags;
  assign push_code = key_of(int'(push_row), samp_col);

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst)         flags <= '0;
    else if (samp_q) flags <= flag_set;
    else             flags <= flags & (flags - 1'b1);  // retire lowest set bit
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [CODE_W:0] mem [FIFO_DEPTH];  // {release, code}
  logic [CODE_W:0] head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, pop, push, drop;

  assign full     = (ev_count == CNT_W'(FIFO_DEPTH));
  assign ev_valid = (ev_count != '0);
  assign pop      = ev_valid && ev_ready;
  // A pop frees the slot in the same cycle, so a push at full still lands.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // key_down already holds the post-flip state, so a cleared bit means release.
  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are live, and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_100MHz) begin
    if (push) mem[wr_ptr] <= {~key_down[push_code], push_code};
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   ev_count <= ev_count + 1'b1;
        2'b01:   ev_count <= ev_count - 1'b1;
        default: ev_count <= ev_count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    ev_code    = '0;
    ev_release = 1'b0;
    if (ev_valid) begin
      ev_code    = head[CODE_W-1:0];
      ev_release = head[CODE_W];
    end
  end

endmodule
